// File: rtl/bf2.sv
// bf2: parametrised Brainfuck execution core with valid/ready IO, HALT and stack faults.
// Define BF2_INSN_COUNT_EN to build the retired-instruction counter; otherwise insn_count is 0.
module bf2 #(
   parameter int DATA_WIDTH  = 8,
   parameter int DADDR_WIDTH = 15,
   parameter int CADDR_WIDTH = 13,
   parameter int DEPTH       = 6
) (
   input  logic                   clk,
   input  logic                   resetq,
   output logic [CADDR_WIDTH-1:0] code_addr,
   input  logic [7:0]             insn,
   output logic [DADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0]  mem_din,
   output logic [DATA_WIDTH-1:0]  mem_dout,
   output logic                   mem_wr,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   halted,
   output logic                   fault,
   output logic [1:0]             fault_code,
   output logic [31:0]            insn_count
);

   // state   | meaning
   // S_RUN   | decode and execute one instruction per cycle
   // S_LONG  | second byte of a long '[' (offset high bits in h_q)
   // S_HALT  | 0xFF executed; frozen until reset
   // S_FAULT | return-stack over/underflow; frozen until reset
   typedef enum logic [1:0] {S_RUN, S_LONG, S_HALT, S_FAULT} state_t;

   localparam logic [DEPTH-1:0] RSP_MAX = '1;

   state_t                 state_q, state_d;
   logic [CADDR_WIDTH-1:0] pc_q, pc_d;
   logic [DADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [DEPTH-1:0]       rsp_q, rsp_d;
   logic [4:0]             h_q, h_d;
   logic [1:0]             fc_q, fc_d;
   logic [CADDR_WIDTH-1:0] stack_q [2**DEPTH];
   logic [CADDR_WIDTH-1:0] jmp_off;
   logic [DATA_WIDTH-1:0]  dout;
   logic                   wr, in_rdy, out_vld, stall, push, is_open;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ptr_d   = ptr_q;
      rsp_d   = rsp_q;
      h_d     = h_q;
      fc_d    = fc_q;
      dout    = mem_din;
      wr      = 1'b0;
      in_rdy  = 1'b0;
      out_vld = 1'b0;
      stall   = 1'b0;
      push    = 1'b0;
      is_open = 1'b0;
      jmp_off = (state_q == S_LONG) ? CADDR_WIDTH'({{19{h_q[4]}}, h_q, insn})
                                    : CADDR_WIDTH'(insn[4:0]);
      case (state_q)
         S_RUN: begin
            pc_d = pc_q + CADDR_WIDTH'(1);
            unique case (insn[7:5])
               3'b000, 3'b001: ptr_d = ptr_q + DADDR_WIDTH'({{26{insn[5]}}, insn[5:0]});
               3'b010, 3'b011: begin
                  wr   = 1'b1;
                  dout = mem_din + DATA_WIDTH'({{26{insn[5]}}, insn[5:0]});
               end
               3'b100: begin
                  if (insn[4:0] != 5'd0) begin
                     is_open = 1'b1;
                  end else if (rsp_q == '0) begin
                     state_d = S_FAULT;
                     fc_d    = 2'b10;
                     pc_d    = pc_q;
                  end else if (mem_din != '0) begin
                     pc_d = stack_q[rsp_q - DEPTH'(1)];
                  end else begin
                     rsp_d = rsp_q - DEPTH'(1);
                  end
               end
               3'b101: begin
                  h_d     = insn[4:0];
                  state_d = S_LONG;
               end
               3'b110: begin
                  in_rdy = 1'b1;
                  if (in_valid) begin
                     wr   = 1'b1;
                     dout = in_data;
                  end else begin
                     stall = 1'b1;
                  end
               end
               3'b111: begin
                  if (insn == 8'hFF) begin
                     state_d = S_HALT;
                     pc_d    = pc_q;
                  end else begin
                     out_vld = 1'b1;
                     stall   = !out_ready;
                  end
               end
            endcase
         end
         S_LONG: begin
            pc_d    = pc_q + CADDR_WIDTH'(1);
            state_d = S_RUN;
            is_open = 1'b1;
         end
         default: ;
      endcase
      // Short and long '[' share the enter/skip/overflow handling.
      if (is_open) begin
         if (mem_din != '0) begin
            if (rsp_q == RSP_MAX) begin
               state_d = S_FAULT;
               fc_d    = 2'b01;
               pc_d    = pc_q;
            end else begin
               push  = 1'b1;
               rsp_d = rsp_q + DEPTH'(1);
            end
         end else begin
            pc_d = pc_q + jmp_off;
         end
      end
      if (stall) pc_d = pc_q;
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state_q <= S_RUN;
         pc_q    <= '0;
         ptr_q   <= '0;
         rsp_q   <= '0;
         h_q     <= '0;
         fc_q    <= 2'b00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ptr_q   <= ptr_d;
         rsp_q   <= rsp_d;
         h_q     <= h_d;
         fc_q    <= fc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && resetq) stack_q[rsp_q] <= pc_q + CADDR_WIDTH'(1);
   end

`ifdef BF2_INSN_COUNT_EN
   logic        retire;
   logic [31:0] cnt_q;
   // Long jumps retire on their second byte; a faulting instruction does not retire.
   assign retire = (state_d != S_FAULT) &&
                   ((state_q == S_LONG) ||
                    (state_q == S_RUN && !stall && insn[7:5] != 3'b101));
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq)     cnt_q <= '0;
      else if (retire) cnt_q <= cnt_q + 32'd1;
   end
   assign insn_count = cnt_q;
`else
   assign insn_count = '0;
`endif

   assign code_addr  = resetq ? pc_d  : '0;
   assign mem_addr   = resetq ? ptr_d : '0;
   assign mem_wr     = resetq & wr;
   assign in_ready   = resetq & in_rdy;
   assign out_valid  = resetq & out_vld;
   assign mem_dout   = dout;
   assign out_data   = mem_din;
   assign halted     = (state_q == S_HALT);
   assign fault      = (state_q == S_FAULT);
   assign fault_code = fc_q;

endmodule

// File: tb/tb_bf2.sv
// Directed bench for bf2 with behavioural code ROM and write-first tape RAM.
module tb_bf2;

   logic        clk, resetq;
   logic [12:0] code_addr;
   logic [7:0]  insn;
   logic [14:0] mem_addr;
   logic [7:0]  mem_din, mem_dout, in_data, out_data;
   logic        mem_wr, in_valid, in_ready, out_valid, out_ready;
   logic        halted, fault;
   logic [1:0]  fault_code;
   logic [31:0] insn_count;

   logic [7:0]  code [8192];
   logic [7:0]  tape [32768];
   logic        tb_clr;
   int          wr_cnt, xfers, total, bad, w0, x0;

`ifdef BF2_INSN_COUNT_EN
   localparam bit CE = 1'b1;
`else
   localparam bit CE = 1'b0;
`endif

   bf2 #(.DEPTH(2)) dut (
      .clk(clk), .resetq(resetq), .code_addr(code_addr), .insn(insn),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_wr(mem_wr),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .halted(halted), .fault(fault), .fault_code(fault_code), .insn_count(insn_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tb_clr) begin
         for (int i = 0; i < 32768; i++) tape[i] <= 8'h00;
      end else if (mem_wr) begin
         tape[mem_addr] <= mem_dout;
      end
      mem_din <= mem_wr ? mem_dout : tape[mem_addr];
      insn    <= code[code_addr];
      if (mem_wr) wr_cnt <= wr_cnt + 1;
      if (out_valid && out_ready) xfers <= xfers + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic fill_code();
      for (int i = 0; i < 8192; i++) code[i] = 8'hFF;
   endtask

   task automatic do_reset();
      resetq = 1'b0; in_valid = 1'b0; out_ready = 1'b0; tb_clr = 1'b1;
      tick();
      tb_clr = 1'b0;
      tick();
      resetq = 1'b1;
      #1;
      w0 = wr_cnt; x0 = xfers;
   endtask

   initial begin
      total = 0; bad = 0; wr_cnt = 0; xfers = 0;
      resetq = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; tb_clr = 1'b0;

      // program "+5 > -3 FF"
      fill_code();
      code[0] = 8'h45; code[1] = 8'h01; code[2] = 8'h7D; code[3] = 8'hFF;
      tb_clr = 1'b1;
      tick();
      tb_clr = 1'b0;
      tick();
      check("rst_code_addr", 32'(code_addr), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_strobes", {29'd0, mem_wr, in_ready, out_valid}, 0);
      check("rst_status", {29'd0, halted, fault_code}, 0);
      check("rst_fault", 32'(fault), 0);
      check("rst_count", insn_count, 0);
      resetq = 1'b1;
      #1;
      tick(3);
      check("p1_not_halted", 32'(halted), 0);
      tick();
      check("p1_halted", 32'(halted), 1);
      tick(3);
      check("p1_tape0", 32'(tape[0]), 32'h05);
      check("p1_tape1", 32'(tape[1]), 32'hFD);
      check("p1_pc_frozen", 32'(code_addr), 3);
      check("p1_ptr", 32'(mem_addr), 1);
      check("p1_count", insn_count, CE ? 4 : 0);

      // input stall: four cycles without data, then 0x41
      fill_code();
      code[0] = 8'hC0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         check("in_stall_ready", 32'(in_ready), 1);
         check("in_stall_pc", 32'(code_addr), 0);
         check("in_stall_wr", 32'(mem_wr), 0);
         tick();
      end
      in_valid = 1'b1; in_data = 8'h41;
      #1;
      check("in_take_ready", 32'(in_ready), 1);
      check("in_take_pc", 32'(code_addr), 1);
      tick();
      in_valid = 1'b0;
      #1;
      check("in_after_ready", 32'(in_ready), 0);
      check("in_tape0", 32'(tape[0]), 32'h41);
      check("in_writes", 32'(wr_cnt - w0), 1);

      // output backpressure on cell 0x7A
      fill_code();
      code[0] = 8'h5F; code[1] = 8'h5F; code[2] = 8'h5F; code[3] = 8'h5D; code[4] = 8'hE0;
      do_reset();
      tick(4);
      for (int i = 0; i < 3; i++) begin
         check("out_hold_valid", 32'(out_valid), 1);
         check("out_hold_data", 32'(out_data), 32'h7A);
         check("out_hold_pc", 32'(code_addr), 4);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("out_take_valid", 32'(out_valid), 1);
      tick();
      out_ready = 1'b0;
      #1;
      check("out_xfer_one", 32'(xfers - x0), 1);
      check("out_valid_drop", 32'(out_valid), 0);
      tick(3);
      check("out_xfer_still_one", 32'(xfers - x0), 1);
      check("out_halted", 32'(halted), 1);

      // loop: +3 [ -1 ] FF
      fill_code();
      code[0] = 8'h43; code[1] = 8'h83; code[2] = 8'h7F; code[3] = 8'h80;
      do_reset();
      tick(8);
      check("loop_not_halted", 32'(halted), 0);
      tick();
      check("loop_halted", 32'(halted), 1);
      check("loop_fault", 32'(fault), 0);
      check("loop_cell", 32'(tape[0]), 0);
      check("loop_writes", 32'(wr_cnt - w0), 4);
      check("loop_rsp", 32'(dut.rsp_q), 0);
      check("loop_count", insn_count, CE ? 9 : 0);

      // long jump skip over zero cell
      fill_code();
      code[0] = 8'hA1; code[1] = 8'h10; code[12'h110] = 8'h00; code[13'h111] = 8'hFF;
      do_reset();
      check("long_pc1", 32'(code_addr), 1);
      tick();
      check("long_target", 32'(code_addr), 32'h111);
      check("long_mid_halt", 32'(halted), 0);
      tick();
      check("long_landed_halt", 32'(halted), 0);
      tick();
      check("long_halted", 32'(halted), 1);
      check("long_pc_final", 32'(code_addr), 32'h111);

      // underflow at reset
      fill_code();
      code[0] = 8'h80;
      do_reset();
      tick();
      check("uf_fault", 32'(fault), 1);
      check("uf_code", 32'(fault_code), 2);
      tick(2);
      check("uf_pc_frozen", 32'(code_addr), 0);
      check("uf_halted", 32'(halted), 0);

      // overflow on fourth nested '[' with DEPTH=2
      fill_code();
      code[0] = 8'h41; code[1] = 8'h81; code[2] = 8'h81; code[3] = 8'h81; code[4] = 8'h81;
      do_reset();
      tick(4);
      check("of_pre_fault", 32'(fault), 0);
      tick();
      check("of_fault", 32'(fault), 1);
      check("of_code", 32'(fault_code), 1);
      check("of_pc", 32'(code_addr), 4);
      tick(2);
      check("of_frozen_pc", 32'(code_addr), 4);
      check("of_frozen_wr", 32'(wr_cnt - w0), 1);
      resetq = 1'b0;
      #1;
      check("of_rst_fault", 32'(fault), 0);
      check("of_rst_code", 32'(fault_code), 0);
      fill_code();
      code[0] = 8'h01;
      do_reset();
      check("recover_run", {30'd0, fault, halted}, 0);
      tick();
      check("recover_ptr", 32'(mem_addr), 1);

      // reset mid-stall issues no write
      fill_code();
      code[0] = 8'hC0;
      do_reset();
      tick(2);
      resetq = 1'b0; in_valid = 1'b1; in_data = 8'h55;
      #1;
      check("midrst_wr", 32'(mem_wr), 0);
      check("midrst_ready", 32'(in_ready), 0);
      tick(2);
      check("midrst_writes", 32'(wr_cnt - w0), 0);
      check("midrst_tape0", 32'(tape[0]), 0);
      in_valid = 1'b0;
      resetq = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
